switch_debounce_toggle: RTL and testbench

- Input-side conditioner for a raw mechanical board switch.
- Synchronises the switch, rejects bounce, and emits one-cycle press and release pulses.
- Keeps a toggling LED state and a press counter.
- Sits between the board switch pin and the LED and other logic, so consumers see one clean event per physical actuation instead of the raw level.

---
 rtl/switch_debounce_toggle.sv | 140 ++++++++++++++
 tb/tb_switch_debounce_toggle.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_toggle.sv
// switch_debounce_toggle: two-flop synchroniser, counter-based debouncer, press/release
// pulses, toggling LED and modulo press counter for a raw mechanical switch.
`default_nettype none

module switch_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch,
  output logic             led,
  output logic             stable,
  output logic             pressed,
  output logic             released,
  output logic [CNT_W-1:0] press_count
);

  localparam int               DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  ACCEPT_AT = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [DB_W-1:0] db_cnt, db_cnt_n;
  logic            s1, s2;
  logic            rise, fall;

  // s1 is the only flop that sees the raw, possibly metastable switch level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= switch;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE_LOW;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      db_cnt <= db_cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    db_cnt_n = db_cnt;
    rise     = 1'b0;
    fall     = 1'b0;
    case (state)
      IDLE_LOW: begin
        db_cnt_n = '0;
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            rise    = 1'b1;
            state_n = IDLE_HIGH;
          end else begin
            state_n  = WAIT_HIGH;
            db_cnt_n = DB_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_n  = IDLE_LOW;
          db_cnt_n = '0;
        end else if (db_cnt == ACCEPT_AT) begin
          rise     = 1'b1;
          state_n  = IDLE_HIGH;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_cnt + DB_ONE;
        end
      end
      IDLE_HIGH: begin
        db_cnt_n = '0;
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            fall    = 1'b1;
            state_n = IDLE_LOW;
          end else begin
            state_n  = WAIT_LOW;
            db_cnt_n = DB_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_n  = IDLE_HIGH;
          db_cnt_n = '0;
        end else if (db_cnt == ACCEPT_AT) begin
          fall     = 1'b1;
          state_n  = IDLE_LOW;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_n  = IDLE_LOW;
        db_cnt_n = '0;
      end
    endcase
  end

  // All accept-side outputs update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable      <= 1'b0;
      pressed     <= 1'b0;
      released    <= 1'b0;
      led         <= 1'b0;
      press_count <= '0;
    end else begin
      pressed  <= rise;
      released <= fall;
      if (rise) begin
        stable      <= 1'b1;
        led         <= ~led;
        press_count <= press_count + CNT_W'(1);
      end else if (fall) begin
        stable <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce_toggle.sv
// tb_switch_debounce_toggle: directed checks of switch_debounce_toggle with
// DEBOUNCE_CYCLES=4, CNT_W=4 (accept visible 6 sampling points after the step).
`default_nettype none

module tb_switch_debounce_toggle;

  logic       clk = 1'b0;
  logic       rst;
  logic       switch;
  logic       led, stable, pressed, released;
  logic [3:0] press_count;

  int compared   = 0;
  int mismatched = 0;
  int n_press    = 0;
  int n_release  = 0;
  int n_viol     = 0;
  int last_kind  = 0;  // 0 none, 1 pressed, 2 released
  int p0, r0;

  switch_debounce_toggle #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .switch      (switch),
    .led         (led),
    .stable      (stable),
    .pressed     (pressed),
    .released    (released),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts pulses, flags overlap or non-alternation.
  always @(posedge clk) begin
    #1;
    if (pressed && released) n_viol++;
    if (pressed) begin
      n_press++;
      if (last_kind == 1) n_viol++;
      last_kind = 1;
    end
    if (released) begin
      n_release++;
      if (last_kind == 2) n_viol++;
      last_kind = 2;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic s, input logic p,
                         input logic r, input logic [3:0] c);
    chk({tag, ".led"}, 32'(led), 32'(l));
    chk({tag, ".stable"}, 32'(stable), 32'(s));
    chk({tag, ".pressed"}, 32'(pressed), 32'(p));
    chk({tag, ".released"}, 32'(released), 32'(r));
    chk({tag, ".count"}, 32'(press_count), 32'(c));
  endtask

  initial begin
    rst    = 1'b1;
    switch = 1'b0;
    tick(3);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    tick(20);
    chk_all("idle20", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("idle20.npress", n_press, 0);
    chk("idle20.nrel", n_release, 0);

    // Clean press: visible at the 6th sampling point after the step.
    switch = 1'b1;
    tick(5);
    chk("press.before", 32'(stable), 32'd0);
    tick(1);
    chk_all("press.accept", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick(1);
    chk("press.pulse_end", 32'(pressed), 32'd0);

    // Clean release.
    switch = 1'b0;
    tick(5);
    chk("rel.before", 32'(stable), 32'd1);
    tick(1);
    chk_all("rel.accept", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    tick(1);
    chk("rel.pulse_end", 32'(released), 32'd0);

    // Bounce 1,0,1,1,0 then final 1 held.
    p0 = n_press;
    switch = 1'b1; tick(1);
    switch = 1'b0; tick(1);
    switch = 1'b1; tick(2);
    switch = 1'b0; tick(1);
    switch = 1'b1;
    tick(5);
    chk("bounce.no_pulse", n_press, p0);
    chk("bounce.stable_lo", 32'(stable), 32'd0);
    tick(1);
    chk_all("bounce.accept", 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    tick(1);
    chk("bounce.one_pulse", n_press, p0 + 1);

    switch = 1'b0;
    tick(6);
    chk_all("rel2.accept", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);

    // Fresh reset, then 17 press/release cycles to wrap the 4-bit counter.
    rst = 1'b1;
    tick(2);
    chk_all("reset2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick(2);
    p0 = n_press;
    r0 = n_release;
    for (int i = 0; i < 17; i++) begin
      switch = 1'b1;
      tick(8);
      if (i == 15) chk("wrap.zero", 32'(press_count), 32'd0);
      switch = 1'b0;
      tick(8);
    end
    chk_all("wrap17", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
    chk("wrap17.npress", n_press - p0, 17);
    chk("wrap17.nrel", n_release - r0, 17);

    // Reset in the 3rd cycle of WAIT_HIGH cancels the pending accept.
    switch = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk_all("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    p0 = n_press;
    tick(5);
    chk("rst_wait.before", 32'(stable), 32'd0);
    chk("rst_wait.no_pulse", n_press, p0);
    tick(1);
    chk_all("rst_wait.accept", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);

    tick(2);
    chk("pulse_rules", n_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
